pe_help_arb_rr: RTL and testbench
=================================

Name: pe_help_arb_rr

Overview:
- Parametrised round-robin work-sharing arbiter for one PE block.
- Walks activation rows 0..LENROW-1 in order. Per row, it hands each still-needed weight (GRP groups × KER×KER taps) to one idle MAC, at most one grant per cycle.
- Gates each grant on availability of the target partial-sum (PSUM) buffer and counts contributions per PSUM.
- Successor of the fixed 27-MAC arbiter: adds generic kernel/group/row sizing, round-robin MAC selection and an explicit DRAIN state.

Parameters:
- KER, 3, kernel dimension (taps per kernel row).
- GRP, 3, weight groups (channels) per block.
- MAC_NUM, GRP*KER*KER, number of MACs; equals weights per row.
- LENROW, 16, activation rows per block; must be ≥ KER.
- PSUM_NUM, GRP*KER, number of PSUM buffers.
- PSUM_DEPTH, KER*KER, grants that complete one PSUM.
- ROW_W, clog2(LENROW); MAC_W, clog2(MAC_NUM); PS_W, clog2(PSUM_NUM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sta  in  1  start block; honoured only in IDLE.
- row_rdy  in  ROW_W+1  number of activation rows whose flags are counted (rows usable = 0..row_rdy-1).
- mac_req  in  MAC_NUM  MAC idle / requests work; assertion by a busy MAC means it has finished.
- psum_empty  in  PSUM_NUM  PSUM buffer idle.
- arb_fnh  out  1  high in IDLE.
- grant_vld  out  1  one-cycle grant pulse.
- grant_mac  out  MAC_NUM  one-hot MAC reset/grant; same cycle as grant_vld.
- grant_row  out  ROW_W  activation row of the grant.
- grant_wei  out  MAC_W  weight index of the grant.
- grant_psum  out  PS_W  target PSUM of the grant.
- mac_busy  out  MAC_NUM  MAC switched on.
- row_on  out  1  registered: all weights of the current row dispatched.
- cur_row  out  ROW_W  current arbitration row.
- psum_fnh  out  PSUM_NUM  PSUM closed.

Behaviour:

Indexing
- Weight index: w = g*KER*KER + kr*KER + kc.
- Weight w is needed in row r iff kr ≤ r and r−kr ≤ LENROW−KER.
- PSUM mapping: psum(w,r) = g*KER + ((r−kr) mod KER).

States: IDLE, ARB, DRAIN (2-bit register).
- IDLE→ARB on sta.
- ARB→DRAIN when cur_row = LENROW−1 and all its needed weights are dispatched.
- DRAIN→IDLE when mac_busy = 0.
- sta outside IDLE is ignored.

Reset (async, or on entering IDLE)
- cur_row = 0, done-flags = 0, rr pointer = 0, cnt[] = 0.
- All grant outputs = 0; mac_busy = 0; row_on = 0.
- psum_fnh = all 1; arb_fnh = 1.

Eligibility (ARB only, combinational)
- Weight w is eligible iff: needed in cur_row, not done, and (psum_fnh[p] == 0 or psum_empty[p] == 1).
- Weight selection: lowest-index eligible weight.
- MAC eligibility: mac_req & ~grant_mac, which masks a MAC during its grant turnaround.
- MAC selection: first eligible MAC at or after the rr pointer, wrapping at MAC_NUM.

Grant
- A grant occurs iff both an eligible weight and an eligible MAC exist and the row is not advancing this cycle.
- Outputs are registered: grant_* are valid exactly 1 cycle after selection.
- Done-flag for w is set.
- rr pointer ← (selected MAC + 1) mod MAC_NUM.

mac_busy
- Next value: (mac_busy & ~mac_req) | grant_mac_next.
- If a MAC is granted in the same cycle it is released, set wins.

Row advance
- Condition: all needed weights of cur_row done, cur_row < LENROW−1, and cur_row+1 < row_rdy.
- Action: cur_row++, done-flags cleared.
- Otherwise cur_row holds; row_on stays 1 and no grants issue.
- row_on is a 1-cycle-delayed copy of "all done".

PSUM counters
- On a grant to p with psum_fnh[p] = 1 (requires psum_empty[p]): psum_fnh[p] ← 0, cnt ← 1.
- On a grant to p with psum_fnh[p] = 0: cnt++.
- When cnt would reach PSUM_DEPTH: psum_fnh[p] ← 1, cnt ← 0.
- If PSUM_DEPTH = 1, an opening grant also closes the PSUM.

Totals
- Default configuration issues 378 grants per block.

Decomposition:
- Shared package:
  - clog2 function.
  - State encodings.
  - Helper functions wei_needed(w,r) and wei2psum(w,r).
- Sub-module: rr_pick (rotating first-one finder; outputs one-hot and index), instantiated once for MACs.
- Weight selection reuses rr_pick with the pointer tied to 0.

Test Plan:
- Reset: rst_n = 0 mid-ARB → next edge arb_fnh = 1, psum_fnh = 9'h1FF, mac_busy = 0, cur_row = 0, grant_vld = 0.
- Defaults, sta, row_rdy = 16, mac_req = 27'h1 pulsed after each grant, psum_empty = all 1:
  - first grant: row 0, wei 0, psum 0.
  - row-0 grants: weis 0,1,2,9,10,11,18,19,20.
  - total grants: 378.
  - finish: DRAIN, then IDLE once busy clears.
- Round-robin: mac_req = 27'h7 held, MACs never finish → grant_mac = 1, 2, 4, then no more grants (all busy); mac_busy = 27'h7.
- Row stall: row_rdy = 1 → exactly 9 grants; row_on = 1; cur_row stays 0; releasing row_rdy = 2 → cur_row = 1 next cycle, then 18 grants for row 1.
- PSUM gating: psum_empty = 0 after sta → no grants.
  - Set psum_empty[0] = 1 → grants only for weis 0,1,2 (psum 0); psum_fnh[0] = 0.
- PSUM close: psum 0 receives 9 grants → psum_fnh[0] = 1 on the 9th grant's cycle; further psum-0 weights wait for psum_empty[0].

Source files
------------

// File: rtl/pe_help_arb_rr_pkg.sv
// Shared types and index helpers for the round-robin PE work-sharing arbiter.
// Weight w = g*KER*KER + kr*KER + kc; PSUM = g*KER + ((r-kr) mod KER).
package pe_help_arb_rr_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic wei_needed(
    input int w,
    input int r,
    input int ker,
    input int lenrow
  );
    int kr;
    kr = (w % (ker * ker)) / ker;
    return (kr <= r) && ((r - kr) <= (lenrow - ker));
  endfunction

  // Bias by ker so weights not needed in this row still map in range.
  function automatic int wei2psum(
    input int w,
    input int r,
    input int ker
  );
    int g;
    int kr;
    g  = w / (ker * ker);
    kr = (w % (ker * ker)) / ker;
    return g * ker + ((r - kr + ker) % ker);
  endfunction

endpackage

// File: rtl/pe_help_arb_rr_rr_pick.sv
// Rotating first-one finder: first set request at or after ptr,
// wrapping at N; one-hot and binary index outputs.
module pe_help_arb_rr_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[W'(j)]) begin
        any         = 1'b1;
        gnt[W'(j)]  = 1'b1;
        idx         = W'(j);
      end
    end
  end

endmodule

// File: rtl/pe_help_arb_rr.sv
// Round-robin work-sharing arbiter: walks activation rows, hands each
// needed weight to one idle MAC per cycle, gated by PSUM availability.
module pe_help_arb_rr
  import pe_help_arb_rr_pkg::*;
#(
  parameter int KER        = 3,
  parameter int GRP        = 3,
  parameter int MAC_NUM    = GRP * KER * KER,
  parameter int LENROW     = 16,
  parameter int PSUM_NUM   = GRP * KER,
  parameter int PSUM_DEPTH = KER * KER,
  parameter int ROW_W      = clog2(LENROW),
  parameter int MAC_W      = clog2(MAC_NUM),
  parameter int PS_W       = clog2(PSUM_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sta,
  input  logic [ROW_W:0]      row_rdy,
  input  logic [MAC_NUM-1:0]  mac_req,
  input  logic [PSUM_NUM-1:0] psum_empty,
  output logic                arb_fnh,
  output logic                grant_vld,
  output logic [MAC_NUM-1:0]  grant_mac,
  output logic [ROW_W-1:0]    grant_row,
  output logic [MAC_W-1:0]    grant_wei,
  output logic [PS_W-1:0]     grant_psum,
  output logic [MAC_NUM-1:0]  mac_busy,
  output logic                row_on,
  output logic [ROW_W-1:0]    cur_row,
  output logic [PSUM_NUM-1:0] psum_fnh
);

  localparam int CNT_W = clog2(PSUM_DEPTH + 1);

  logic [1:0]                     state;
  logic [MAC_NUM-1:0]             done;
  logic [MAC_NUM-1:0]             need;
  logic [MAC_NUM-1:0]             elig_w;
  logic [MAC_NUM-1:0]             mac_elig;
  logic [MAC_NUM-1:0]             w_gnt;
  logic [MAC_NUM-1:0]             m_gnt;
  logic [MAC_NUM-1:0]             gmac;
  logic [MAC_W-1:0]               w_idx;
  logic [MAC_W-1:0]               m_idx;
  logic [MAC_W-1:0]               rr_ptr;
  logic [PS_W-1:0]                sel_p;
  logic [PSUM_NUM-1:0][CNT_W-1:0] cnt;
  logic                           w_any;
  logic                           m_any;
  logic                           arb;
  logic                           all_done;
  logic                           last_row;
  logic                           advance;
  logic                           grant;

  assign arb     = state == ST_ARB;
  assign arb_fnh = state == ST_IDLE;

  for (genvar w = 0; w < MAC_NUM; w++) begin : g_wei
    logic [PS_W-1:0] p;
    assign need[w]   = wei_needed(w, int'(cur_row), KER, LENROW);
    assign p         = PS_W'(wei2psum(w, int'(cur_row), KER));
    assign elig_w[w] = arb && need[w] && !done[w]
                       && (!psum_fnh[p] || psum_empty[p]);
  end

  assign all_done = &(done | ~need);
  assign last_row = cur_row == ROW_W'(LENROW - 1);
  assign advance  = arb && all_done && !last_row
                    && (({1'b0, cur_row} + (ROW_W+1)'(1)) < row_rdy);

  // A MAC in its grant turnaround still shows mac_req; mask it.
  assign mac_elig = arb ? (mac_req & ~grant_mac) : '0;

  pe_help_arb_rr_rr_pick #(.N(MAC_NUM), .W(MAC_W)) u_wpick (
    .req (elig_w),
    .ptr ('0),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  pe_help_arb_rr_rr_pick #(.N(MAC_NUM), .W(MAC_W)) u_mpick (
    .req (mac_elig),
    .ptr (rr_ptr),
    .gnt (m_gnt),
    .idx (m_idx),
    .any (m_any)
  );

  assign grant = w_any && m_any && !advance;
  assign gmac  = grant ? m_gnt : '0;
  assign sel_p = PS_W'(wei2psum(int'(w_idx), int'(cur_row), KER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_row    <= '0;
      done       <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      psum_fnh   <= '1;
      mac_busy   <= '0;
      row_on     <= 1'b0;
      grant_vld  <= 1'b0;
      grant_mac  <= '0;
      grant_row  <= '0;
      grant_wei  <= '0;
      grant_psum <= '0;
    end else begin
      grant_vld  <= grant;
      grant_mac  <= gmac;
      grant_row  <= grant ? cur_row : '0;
      grant_wei  <= grant ? w_idx : '0;
      grant_psum <= grant ? sel_p : '0;
      mac_busy   <= (mac_busy & ~mac_req) | gmac;
      row_on     <= arb && all_done;
      if (grant) begin
        done   <= done | w_gnt;
        rr_ptr <= (m_idx == MAC_W'(MAC_NUM - 1)) ? '0
                  : m_idx + MAC_W'(1);
        if (psum_fnh[sel_p]) begin
          psum_fnh[sel_p] <= (PSUM_DEPTH == 1);
          cnt[sel_p]      <= (PSUM_DEPTH == 1) ? '0 : CNT_W'(1);
        end else if (cnt[sel_p] == CNT_W'(PSUM_DEPTH - 1)) begin
          psum_fnh[sel_p] <= 1'b1;
          cnt[sel_p]      <= '0;
        end else begin
          cnt[sel_p] <= cnt[sel_p] + CNT_W'(1);
        end
      end
      if (advance) begin
        cur_row <= cur_row + ROW_W'(1);
        done    <= '0;
      end
      unique case (state)
        ST_IDLE: if (sta) state <= ST_ARB;
        ST_ARB:  if (all_done && last_row) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (mac_busy == '0) begin
            state    <= ST_IDLE;
            cur_row  <= '0;
            done     <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            psum_fnh <= '1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_help_arb_rr.sv
// Bench for pe_help_arb_rr: grant scoreboard, row-stall table,
// round-robin, PSUM gating/close and asynchronous reset sequences.
module tb_pe_help_arb_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sta = 1'b0;
  logic [4:0]  row_rdy;
  logic [26:0] mac_req;
  logic [8:0]  psum_empty;
  logic        arb_fnh;
  logic        grant_vld;
  logic [26:0] grant_mac;
  logic [3:0]  grant_row;
  logic [4:0]  grant_wei;
  logic [3:0]  grant_psum;
  logic [26:0] mac_busy;
  logic        row_on;
  logic [3:0]  cur_row;
  logic [8:0]  psum_fnh;

  pe_help_arb_rr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sta        (sta),
    .row_rdy    (row_rdy),
    .mac_req    (mac_req),
    .psum_empty (psum_empty),
    .arb_fnh    (arb_fnh),
    .grant_vld  (grant_vld),
    .grant_mac  (grant_mac),
    .grant_row  (grant_row),
    .grant_wei  (grant_wei),
    .grant_psum (grant_psum),
    .mac_busy   (mac_busy),
    .row_on     (row_on),
    .cur_row    (cur_row),
    .psum_fnh   (psum_fnh)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  row;
    logic [4:0]  wei;
    logic [3:0]  psum;
    logic [26:0] mac;
  } gexp_t;

  typedef struct {
    int   rdy;
    int   row;
    int   grants;
    logic ron;
  } stall_t;

  gexp_t  sb[$];
  gexp_t  mon_act;
  gexp_t  mon_exp;
  stall_t tbl[4];
  int     n_chk = 0;
  int     n_fail = 0;
  int     gcnt = 0;
  int     p0cnt = 0;
  bit     sb_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sta   = 1'b0;
    sb_on = 1'b0;
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    gcnt  = 0;
    p0cnt = 0;
  endtask

  task automatic start();
    sta = 1'b1;
    tick(1);
    sta = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && grant_vld) begin
      gcnt++;
      if (grant_psum == 4'd0) p0cnt++;
      if (sb_on) begin
        mon_act = '{row: grant_row, wei: grant_wei,
                    psum: grant_psum, mac: grant_mac};
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: got wei %0d row %0d, expected none",
                   grant_wei, grant_row);
        end else begin
          mon_exp = sb.pop_front();
          check("grant", 64'(mon_act), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    int  k;
    bit  closed;
    bit  found;
    tbl[0] = '{1, 0, 9, 1'b1};
    tbl[1] = '{2, 1, 18, 1'b1};
    tbl[2] = '{3, 2, 27, 1'b1};
    tbl[3] = '{4, 3, 27, 1'b1};
    row_rdy    = 5'd16;
    mac_req    = '0;
    psum_empty = '1;

    // reset state
    tick(1);
    check("rst_arb_fnh", 64'(arb_fnh), 64'd1);
    check("rst_psum_fnh", 64'(psum_fnh), 64'h1FF);
    check("rst_mac_busy", 64'(mac_busy), 64'd0);
    check("rst_cur_row", 64'(cur_row), 64'd0);
    check("rst_grant_vld", 64'(grant_vld), 64'd0);
    check("rst_row_on", 64'(row_on), 64'd0);

    // full block, single MAC, all PSUMs free
    do_reset();
    mac_req    = 27'h1;
    psum_empty = '1;
    row_rdy    = 5'd16;
    for (int r = 0; r < 16; r++) begin
      for (int w = 0; w < 27; w++) begin
        int g;
        int kr;
        g  = w / 9;
        kr = (w % 9) / 3;
        if (kr <= r && (r - kr) <= 13)
          sb.push_back('{row: 4'(r), wei: 5'(w),
                         psum: 4'(g * 3 + (r - kr) % 3), mac: 27'h1});
      end
    end
    sb_on = 1'b1;
    start();
    k = 0;
    while (!(gcnt >= 378 && arb_fnh) && k < 3000) begin
      tick(1);
      k++;
    end
    sb_on = 1'b0;
    check("total_grants", 64'(gcnt), 64'd378);
    check("sb_left", 64'(sb.size()), 64'd0);
    check("end_idle", 64'(arb_fnh), 64'd1);
    check("end_mac_busy", 64'(mac_busy), 64'd0);
    check("end_psum_fnh", 64'(psum_fnh), 64'h1FF);
    check("end_cur_row", 64'(cur_row), 64'd0);

    // round-robin over three MACs that never finish
    do_reset();
    mac_req = 27'h7;
    sb.push_back('{row: 4'd0, wei: 5'd0, psum: 4'd0, mac: 27'h1});
    sb.push_back('{row: 4'd0, wei: 5'd1, psum: 4'd0, mac: 27'h2});
    sb.push_back('{row: 4'd0, wei: 5'd2, psum: 4'd0, mac: 27'h4});
    sb_on = 1'b1;
    start();
    repeat (20) begin
      if (grant_vld) mac_req = mac_req & ~grant_mac;
      tick(1);
    end
    sb_on = 1'b0;
    check("rr_grants", 64'(gcnt), 64'd3);
    check("rr_sb_left", 64'(sb.size()), 64'd0);
    check("rr_mac_busy", 64'(mac_busy), 64'h7);

    // row stall released one row at a time
    do_reset();
    mac_req = 27'h1;
    row_rdy = 5'd1;
    start();
    for (int i = 0; i < 4; i++) begin
      row_rdy = 5'(tbl[i].rdy);
      gcnt    = 0;
      tick(1);
      check("stall_row_step", 64'(cur_row), 64'(tbl[i].row));
      tick(80);
      check("stall_grants", 64'(gcnt), 64'(tbl[i].grants));
      check("stall_cur_row", 64'(cur_row), 64'(tbl[i].row));
      check("stall_row_on", 64'(row_on), 64'(tbl[i].ron));
    end

    // PSUM gating
    do_reset();
    mac_req    = 27'h1;
    row_rdy    = 5'd16;
    psum_empty = '0;
    start();
    tick(20);
    check("gate_none", 64'(gcnt), 64'd0);
    psum_empty = 9'h001;
    sb.push_back('{row: 4'd0, wei: 5'd0, psum: 4'd0, mac: 27'h1});
    sb.push_back('{row: 4'd0, wei: 5'd1, psum: 4'd0, mac: 27'h1});
    sb.push_back('{row: 4'd0, wei: 5'd2, psum: 4'd0, mac: 27'h1});
    sb_on = 1'b1;
    tick(30);
    sb_on = 1'b0;
    check("gate_grants", 64'(gcnt), 64'd3);
    check("gate_sb_left", 64'(sb.size()), 64'd0);
    check("gate_psum_fnh", 64'(psum_fnh), 64'h1FE);

    // PSUM 0 closes on its 9th grant, then waits for psum_empty[0]
    psum_empty = '1;
    closed = 1'b0;
    k = 0;
    while (!closed && k < 400) begin
      tick(1);
      k++;
      if (p0cnt >= 9) begin
        check("psum0_close", 64'(psum_fnh[0]), 64'd1);
        psum_empty[0] = 1'b0;
        closed = 1'b1;
      end
    end
    check("psum0_close_seen", 64'(closed), 64'd1);
    check("psum0_cnt", 64'(p0cnt), 64'd9);
    tick(150);
    check("psum0_wait_cnt", 64'(p0cnt), 64'd9);
    check("psum0_wait_row", 64'(cur_row), 64'd3);
    check("psum0_wait_row_on", 64'(row_on), 64'd0);
    psum_empty[0] = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 10) begin
      tick(1);
      k++;
      if (grant_vld) found = 1'b1;
    end
    check("psum0_reopen_seen", 64'(found), 64'd1);
    check("psum0_reopen_grant",
          64'({grant_row, grant_wei, grant_psum}),
          64'({4'd3, 5'd0, 4'd0}));
    check("psum0_reopen_fnh", 64'(psum_fnh[0]), 64'd0);

    // asynchronous reset in the middle of arbitration
    tick(3);
    check("pre_reset_arb", 64'(arb_fnh), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_arb_fnh", 64'(arb_fnh), 64'd1);
    check("mid_rst_psum_fnh", 64'(psum_fnh), 64'h1FF);
    check("mid_rst_mac_busy", 64'(mac_busy), 64'd0);
    check("mid_rst_cur_row", 64'(cur_row), 64'd0);
    check("mid_rst_grant_vld", 64'(grant_vld), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
